vga_sync_pulse_gen: RTL and testbench

//  Raster timing generator for the VGA output path. Runs horizontal and vertical pixel counters and

---
 rtl/vga_sync_pulse_gen_pkg.sv | 32 +++
 rtl/vga_sync_pulse_gen_if.sv | 41 ++++
 rtl/vga_axis_counter.sv | 64 ++++++
 rtl/vga_sync_pulse_gen.sv | 112 +++++++++++
 tb/tb_vga_sync_pulse_gen.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_sync_pulse_gen_pkg.sv
// vga_sync_pulse_gen_pkg: 640x480@60 raster defaults and timing helpers
// shared by the sync generator and the pixel pipeline.
package vga_sync_pulse_gen_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CW_DEF       = 10;

  function automatic int axis_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  // A sync end that lands exactly on TOTAL happens at count 0.
  function automatic int sync_end_cmp(
    input int s_end,
    input int total
  );
    return (s_end >= total) ? s_end - total : s_end;
  endfunction

endpackage

// File: rtl/vga_sync_pulse_gen_if.sv
// vga_sync_pulse_gen_if: pixel strobe in; sync pulses, coordinates,
// video_on and frame_start out. master = generator, slave = consumer.
interface vga_sync_pulse_gen_if #(
  parameter int CW = 10
);

  logic          pix_en;
  logic          hs_set;
  logic          hs_reset;
  logic          vs_set;
  logic          vs_reset;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          video_on;
  logic          frame_start;

  modport master (
    input  pix_en,
    output hs_set,
    output hs_reset,
    output vs_set,
    output vs_reset,
    output pixel_x,
    output pixel_y,
    output video_on,
    output frame_start
  );

  modport slave (
    output pix_en,
    input  hs_set,
    input  hs_reset,
    input  vs_set,
    input  vs_reset,
    input  pixel_x,
    input  pixel_y,
    input  video_on,
    input  frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis. Ports: clk, reset, inc (advance),
// count, wrap (comb: inc at TOTAL-1), sync_set/sync_reset, active (regs).
module vga_axis_counter
  import vga_sync_pulse_gen_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752,
  parameter int ACTIVE     = 640,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync_set,
  output logic          sync_reset,
  output logic          active
);

  localparam logic [CW-1:0] LAST   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SET_AT = CW'(SYNC_START);
  localparam logic [CW-1:0] RST_AT =
    CW'(sync_end_cmp(SYNC_END, TOTAL));
  localparam logic [CW-1:0] ACT_N  = CW'(ACTIVE);
  localparam logic          ACT_0  = (ACTIVE > 0);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          set_q;
  logic          rst_q;
  logic          act_q;
  logic          last;

  assign last    = (count_q == LAST);
  assign count_d = last ? '0 : count_q + CW'(1);
  assign wrap    = inc & last;

  // Pulses are recomputed every clk, so they drop after one
  // clk even while inc stays low. act_q resets to the value of
  // count 0; the top masks video_on until the first strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      set_q   <= 1'b0;
      rst_q   <= 1'b0;
      act_q   <= ACT_0;
    end else begin
      set_q <= inc & (count_d == SET_AT);
      rst_q <= inc & (count_d == RST_AT);
      if (inc) begin
        count_q <= count_d;
        act_q   <= (count_d < ACT_N);
      end
    end
  end

  assign count      = count_q;
  assign sync_set   = set_q;
  assign sync_reset = rst_q;
  assign active     = act_q;

endmodule

// File: rtl/vga_sync_pulse_gen.sv
// vga_sync_pulse_gen: raster timing top. Ports: clk, reset (async,
// active-high), bus (master: pix_en in; sync pulses, x/y, video_on out).
module vga_sync_pulse_gen
  import vga_sync_pulse_gen_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CW       = CW_DEF
) (
  input logic                  clk,
  input logic                  reset,
  vga_sync_pulse_gen_if.master bus
);

  localparam int H_TOTAL =
    axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int V_TOTAL =
    axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_set;
  logic          h_rst;
  logic          v_set;
  logic          v_rst;
  logic          h_act;
  logic          v_act;
  logic          v_inc;

  logic          arm_q;
  logic          arm_d;
  logic          init_q;
  logic          init_d;
  logic          frame_q;
  logic          frame_d;

  assign v_inc = bus.pix_en & h_wrap;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (HS_START),
    .SYNC_END   (HS_END),
    .ACTIVE     (H_ACTIVE),
    .CW         (CW)
  ) u_h (
    .clk        (clk),
    .reset      (reset),
    .inc        (bus.pix_en),
    .count      (h_cnt),
    .wrap       (h_wrap),
    .sync_set   (h_set),
    .sync_reset (h_rst),
    .active     (h_act)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (VS_START),
    .SYNC_END   (VS_END),
    .ACTIVE     (V_ACTIVE),
    .CW         (CW)
  ) u_v (
    .clk        (clk),
    .reset      (reset),
    .inc        (v_inc),
    .count      (v_cnt),
    .wrap       (v_wrap),
    .sync_set   (v_set),
    .sync_reset (v_rst),
    .active     (v_act)
  );

  // arm_q stays set from reset until the first strobe; that
  // strobe emits one reset pulse to put the latches in a known state.
  assign arm_d   = arm_q & ~bus.pix_en;
  assign init_d  = arm_q & bus.pix_en;
  assign frame_d = v_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_q   <= 1'b1;
      init_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      arm_q   <= arm_d;
      init_q  <= init_d;
      frame_q <= frame_d;
    end
  end

  assign bus.pixel_x     = h_cnt;
  assign bus.pixel_y     = v_cnt;
  assign bus.hs_set      = h_set;
  assign bus.hs_reset    = h_rst | init_q;
  assign bus.vs_set      = v_set;
  assign bus.vs_reset    = v_rst | init_q;
  assign bus.video_on    = h_act & v_act & ~arm_q;
  assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_vga_sync_pulse_gen.sv
// tb_vga_sync_pulse_gen: small-raster and default-raster instances
// checked every clk against an edge-count arithmetic model.
module tb_vga_sync_pulse_gen;

  localparam int CW = 10;

  localparam int AHA = 20;
  localparam int AHF = 3;
  localparam int AHS = 5;
  localparam int AHB = 4;
  localparam int AVA = 6;
  localparam int AVF = 2;
  localparam int AVS = 1;
  localparam int AVB = 0;
  localparam int AHT = AHA + AHF + AHS + AHB;
  localparam int AVT = AVA + AVF + AVS + AVB;

  typedef logic [2*CW+5:0] obs_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  vga_sync_pulse_gen_if #(.CW(CW)) ifa ();
  vga_sync_pulse_gen_if #(.CW(CW)) ifb ();

  vga_sync_pulse_gen #(
    .H_ACTIVE (AHA),
    .H_FP     (AHF),
    .H_SYNC   (AHS),
    .H_BP     (AHB),
    .V_ACTIVE (AVA),
    .V_FP     (AVF),
    .V_SYNC   (AVS),
    .V_BP     (AVB),
    .CW       (CW)
  ) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa)
  );

  vga_sync_pulse_gen dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb)
  );

  obs_t oa;
  obs_t ob;
  assign oa = {ifa.hs_set, ifa.hs_reset, ifa.vs_set,
               ifa.vs_reset, ifa.video_on, ifa.frame_start,
               ifa.pixel_x, ifa.pixel_y};
  assign ob = {ifb.hs_set, ifb.hs_reset, ifb.vs_set,
               ifb.vs_reset, ifb.video_on, ifb.frame_start,
               ifb.pixel_x, ifb.pixel_y};

  // Downstream set-priority latches fed by instance A.
  logic lat_h;
  logic lat_v;
  always @(posedge clk) begin
    if (ifa.hs_set) lat_h <= 1'b1;
    else if (ifa.hs_reset) lat_h <= 1'b0;
    if (ifa.vs_set) lat_v <= 1'b1;
    else if (ifa.vs_reset) lat_v <= 1'b0;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int na = 0;
  int nb = 0;
  bit ea = 1'b0;
  bit eb = 1'b0;
  bit cnt_on = 1'b0;
  int lat_h_cnt = 0;
  int lat_v_cnt = 0;
  int vid_cnt = 0;
  int fs_cnt = 0;

  // Expected outputs after n strobes since reset; e says whether
  // the last clk edge carried a strobe (pulses live one clk only).
  function automatic obs_t model(
    input int ha, input int hf, input int hs, input int hb,
    input int va, input int vf, input int vs, input int vb,
    input int n, input bit e
  );
    int ht, vt, x, y, hss, hse, vss, vse;
    bit p_hs, p_hr, p_vs, p_vr, vid, fs;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    x   = n % ht;
    y   = (n / ht) % vt;
    hss = ha + hf;
    hse = (hss + hs) % ht;
    vss = va + vf;
    vse = (vss + vs) % vt;
    p_hs = e && (x == hss);
    p_hr = e && ((x == hse) || (n == 1));
    p_vs = e && (x == 0) && (y == vss);
    p_vr = e && (((x == 0) && (y == vse)) || (n == 1));
    fs   = e && (x == 0) && (y == 0);
    vid  = (n > 0) && (x < ha) && (y < va);
    return {p_hs, p_hr, p_vs, p_vr, vid, fs,
            CW'(x), CW'(y)};
  endfunction

  function automatic obs_t exp_a();
    return model(AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB,
                 na, ea);
  endfunction

  function automatic obs_t exp_b();
    return model(640, 16, 96, 48, 480, 10, 2, 33, nb, eb);
  endfunction

  task automatic check(input string tag, input int n,
                       input obs_t got, input obs_t exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s n=%0d obs=%h exp=%h", tag, n, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got,
                           input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit en_a, input bit en_b);
    ifa.pix_en = en_a;
    ifb.pix_en = en_b;
    @(posedge clk);
    ea = !rst_a && en_a;
    eb = !rst_b && en_b;
    if (rst_a) na = 0;
    else if (en_a) na++;
    if (rst_b) nb = 0;
    else if (en_b) nb++;
    #1;
    check("A", na, oa, exp_a());
    check("B", nb, ob, exp_b());
    if (cnt_on) begin
      if (lat_h === 1'b1) lat_h_cnt++;
      if (lat_v === 1'b1) lat_v_cnt++;
      if (ea && ifa.video_on) vid_cnt++;
      if (ifa.frame_start) fs_cnt++;
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.pix_en = 1'b0;
    ifb.pix_en = 1'b0;
    repeat (3) step(1'b1, 1'b1);
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1) == 1, 1'b1);

    // Async reset of B mid-line at x=300.
    rst_b = 1'b1;
    nb = 0;
    eb = 1'b0;
    #1;
    check("B async reset", nb, ob, exp_b());
    step(1'b1, 1'b1);
    rst_b = 1'b0;

    // A strobed every 4th clk, B every clk.
    for (int i = 0; i < 1700; i++)
      step((i % 4) == 0, 1'b1);

    // A random strobes with a mid-frame reset.
    for (int i = 0; i < 1500; i++) begin
      if (i == 900) begin
        rst_a = 1'b1;
        na = 0;
        ea = 1'b0;
        #1;
        check("A async reset", na, oa, exp_a());
        step(1'b1, 1'b1);
        rst_a = 1'b0;
      end
      step($urandom_range(0, 3) != 0, 1'b1);
    end

    // A strobed every clk: one warm-up frame, one measured frame.
    repeat (AHT * AVT) step(1'b1, 1'b1);
    cnt_on = 1'b1;
    repeat (AHT * AVT) step(1'b1, 1'b1);
    cnt_on = 1'b0;
    check_int("hsync high clks", lat_h_cnt, AHS * AVT);
    check_int("vsync high clks", lat_v_cnt, AVS * AHT);
    check_int("video_on edges", vid_cnt, AHA * AVA);
    check_int("frame_start count", fs_cnt, 1);
    check_int("latch unknown",
              int'($isunknown({lat_h, lat_v})), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
